// File: rtl/adpll_gear_ctrl_if.sv
// ADPLL gear controller bus: run request, reference clock, phase error in;
// loop enable, gains and lock/fault status out.
interface adpll_gear_ctrl_if #(
  parameter int ERROR_WIDTH = 8,
  parameter int KP_WIDTH    = 3,
  parameter int KI_WIDTH    = 4
);
  logic                          start_i;
  logic                          ref_clk_i;
  logic signed [ERROR_WIDTH-1:0] error_i;
  logic                          enable_o;
  logic [KP_WIDTH-1:0]           kp_o;
  logic [KI_WIDTH-1:0]           ki_o;
  logic                          locked_o;
  logic                          lock_lost_o;
  logic                          fault_o;
  logic [2:0]                    state_o;

  modport master (
    output start_i, ref_clk_i, error_i,
    input  enable_o, kp_o, ki_o, locked_o,
    input  lock_lost_o, fault_o, state_o
  );

  modport slave (
    input  start_i, ref_clk_i, error_i,
    output enable_o, kp_o, ki_o, locked_o,
    output lock_lost_o, fault_o, state_o
  );
endinterface

// File: rtl/adpll_gear_ctrl.sv
// ADPLL gear-shift controller: coarse/fine gain scheduling and lock detect.
// Define ADPLL_GEAR_TIMEOUT_EN to add the acquisition timeout / FAULT state.
module adpll_gear_ctrl #(
  parameter int                 ERROR_WIDTH   = 8,
  parameter int                 KP_WIDTH      = 3,
  parameter int                 KI_WIDTH      = 4,
  parameter logic [KP_WIDTH-1:0] KP_COARSE    = 3'b100,
  parameter logic [KI_WIDTH-1:0] KI_COARSE    = 4'b0100,
  parameter logic [KP_WIDTH-1:0] KP_FINE      = 3'b010,
  parameter logic [KI_WIDTH-1:0] KI_FINE      = 4'b0001,
  parameter int                 COARSE_THRESH = 8,
  parameter int                 LOCK_THRESH   = 2,
  parameter int                 FINE_COUNT    = 8,
  parameter int                 LOCK_COUNT    = 16,
  parameter int                 UNLOCK_COUNT  = 4,
  parameter int                 TIMEOUT_COUNT = 1024
) (
  input logic               fpga_clk_i,
  input logic               reset_n_i,
  adpll_gear_ctrl_if.slave  bus
);

  localparam int EW = ERROR_WIDTH;
  localparam int RM0 = (FINE_COUNT > LOCK_COUNT) ? FINE_COUNT : LOCK_COUNT;
  localparam int RUN_MAX = (RM0 > UNLOCK_COUNT) ? RM0 : UNLOCK_COUNT;
  localparam int RW = $clog2(RUN_MAX + 1);

  localparam logic [EW-1:0] ERR_MIN = {1'b1, {(EW-1){1'b0}}};
  localparam logic [EW-1:0] ERR_MAX = {1'b0, {(EW-1){1'b1}}};
  localparam logic [EW-1:0] C_TH = EW'(COARSE_THRESH);
  localparam logic [EW-1:0] L_TH = EW'(LOCK_THRESH);
  localparam logic [RW-1:0] RUN_SAT = RW'(RUN_MAX);
  localparam logic [RW-1:0] FINE_N = RW'(FINE_COUNT);
  localparam logic [RW-1:0] LOCK_N = RW'(LOCK_COUNT);
  localparam logic [RW-1:0] UNLK_N = RW'(UNLOCK_COUNT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_COARSE = 3'd1,
    S_FINE   = 3'd2,
    S_LOCKED = 3'd3
`ifdef ADPLL_GEAR_TIMEOUT_EN
    , S_FAULT = 3'd4
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   run_q, run_d, run_inc;
  logic            lost_d;
  logic [2:0]      ref_sync;
  logic            strobe;
  logic [EW-1:0]   err_raw, err_neg, abs_err;
  logic            in_coarse, in_lock;

  logic                en_d, lk_d, ft_d;
  logic [KP_WIDTH-1:0] kp_d;
  logic [KI_WIDTH-1:0] ki_d;
  logic                en_q, lk_q, ft_q, lost_q;
  logic [KP_WIDTH-1:0] kp_q;
  logic [KI_WIDTH-1:0] ki_q;

  // Two sync flops, third flop for edge detect, registered strobe.
  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ref_sync <= '0;
      strobe   <= 1'b0;
    end else begin
      ref_sync <= {ref_sync[1:0], bus.ref_clk_i};
      strobe   <= ref_sync[1] & ~ref_sync[2];
    end
  end

  assign err_raw = bus.error_i;
  assign err_neg = -err_raw;

  always_comb begin
    abs_err = err_raw;
    if (err_raw[EW-1]) begin
      abs_err = (err_raw == ERR_MIN) ? ERR_MAX : err_neg;
    end
  end

  assign in_coarse = (abs_err <= C_TH);
  assign in_lock   = (abs_err <= L_TH);
  assign run_inc   = (run_q == RUN_SAT) ? run_q : run_q + 1'b1;

`ifdef ADPLL_GEAR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_COUNT + 1);
  localparam logic [TW-1:0] TO_N = TW'(TIMEOUT_COUNT);
  logic [TW-1:0] to_q, to_d, to_inc;
  logic          acq;

  assign acq    = (state_q == S_COARSE) || (state_q == S_FINE);
  assign to_inc = (to_q == TO_N) ? to_q : to_q + 1'b1;

  always_comb begin
    to_d = '0;
    if (acq) to_d = strobe ? to_inc : to_q;
  end

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) to_q <= '0;
    else            to_q <= to_d;
  end
`endif

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    lost_d  = 1'b0;
    if (!bus.start_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (1'b1)
        (state_q == S_IDLE): state_d = S_COARSE;
        (state_q == S_COARSE): if (strobe) begin
          if (!in_coarse)            run_d = '0;
          else if (run_inc == FINE_N) state_d = S_FINE;
          else                       run_d = run_inc;
        end
        (state_q == S_FINE): if (strobe) begin
          if (in_lock) begin
            if (run_inc == LOCK_N) state_d = S_LOCKED;
            else                   run_d = run_inc;
          end else if (!in_coarse) begin
            state_d = S_COARSE;
          end else begin
            run_d = '0;
          end
        end
        (state_q == S_LOCKED): if (strobe) begin
          if (in_lock) begin
            run_d = '0;
          end else if (run_inc == UNLK_N) begin
            state_d = S_COARSE;
            lost_d  = 1'b1;
          end else begin
            run_d = run_inc;
          end
        end
        default: state_d = state_q;
      endcase
`ifdef ADPLL_GEAR_TIMEOUT_EN
      if (acq && strobe && to_inc == TO_N) begin
        state_d = S_FAULT;
        lost_d  = 1'b0;
      end
`endif
    end
    if (state_d != state_q) run_d = '0;
  end

  // Moore decode of the next state, registered alongside state_q.
  always_comb begin
    en_d = 1'b0;
    lk_d = 1'b0;
    ft_d = 1'b0;
    kp_d = KP_FINE;
    ki_d = KI_FINE;
    unique case (1'b1)
      (state_d == S_COARSE): begin
        en_d = 1'b1;
        kp_d = KP_COARSE;
        ki_d = KI_COARSE;
      end
      (state_d == S_FINE):   en_d = 1'b1;
      (state_d == S_LOCKED): begin
        en_d = 1'b1;
        lk_d = 1'b1;
      end
`ifdef ADPLL_GEAR_TIMEOUT_EN
      (state_d == S_FAULT):  ft_d = 1'b1;
`endif
      default: en_d = 1'b0;
    endcase
  end

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      en_q   <= 1'b0;
      lk_q   <= 1'b0;
      ft_q   <= 1'b0;
      lost_q <= 1'b0;
      kp_q   <= KP_FINE;
      ki_q   <= KI_FINE;
    end else begin
      en_q   <= en_d;
      lk_q   <= lk_d;
      ft_q   <= ft_d;
      lost_q <= lost_d;
      kp_q   <= kp_d;
      ki_q   <= ki_d;
    end
  end

  assign bus.enable_o    = en_q;
  assign bus.locked_o    = lk_q;
  assign bus.lock_lost_o = lost_q;
  assign bus.kp_o        = kp_q;
  assign bus.ki_o        = ki_q;
  assign bus.state_o     = state_q;
`ifdef ADPLL_GEAR_TIMEOUT_EN
  assign bus.fault_o     = ft_q;
`else
  assign bus.fault_o     = 1'b0;
`endif

endmodule

// File: tb/tb_adpll_gear_ctrl.sv
// Directed bench for adpll_gear_ctrl: state transitions are checked by a
// scoreboard of expected Moore outputs, plus point checks at each step.
module tb_adpll_gear_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adpll_gear_ctrl_if #(.ERROR_WIDTH(8), .KP_WIDTH(3), .KI_WIDTH(4)) bus ();

  adpll_gear_ctrl dut (
    .fpga_clk_i (clk),
    .reset_n_i  (rst_n),
    .bus        (bus)
  );

  typedef struct {
    logic [2:0] st;
    logic       en;
    logic [2:0] kp;
    logic [3:0] ki;
    logic       lk;
    logic       ft;
  } exp_t;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] COARSE = 3'd1;
  localparam logic [2:0] FINE = 3'd2;
  localparam logic [2:0] LOCKED = 3'd3;
  localparam logic [2:0] FAULT = 3'd4;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   lost_cnt = 0;
  int   lost_base;
  exp_t sbq[$];
  exp_t e;
  logic [2:0] prev_st = 3'd0;

  function automatic exp_t dec(input logic [2:0] s);
    exp_t r;
    r.st = s; r.en = 1'b0; r.kp = 3'b010; r.ki = 4'b0001;
    r.lk = 1'b0; r.ft = 1'b0;
    case (s)
      COARSE: begin r.en = 1'b1; r.kp = 3'b100; r.ki = 4'b0100; end
      FINE:   r.en = 1'b1;
      LOCKED: begin r.en = 1'b1; r.lk = 1'b1; end
      FAULT:  r.ft = 1'b1;
      default: r.en = 1'b0;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] s);
    sbq.push_back(dec(s));
  endtask

  task automatic pulse(input logic signed [7:0] err, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.error_i   = err;
      bus.ref_clk_i = 1'b1;
      repeat (4) @(negedge clk);
      bus.ref_clk_i = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  // Scoreboard: every state change pops the next expected Moore output.
  always @(negedge clk) begin
    if (bus.lock_lost_o === 1'b1) lost_cnt++;
    if (bus.state_o !== prev_st) begin
      n_cmp++;
      assert (sbq.size() != 0) else begin
        n_bad++;
        $error("FAIL sb_unexpected observed=%0d expected=none", bus.state_o);
      end
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("sb_state", 32'(bus.state_o), 32'(e.st));
        chk("sb_enable", 32'(bus.enable_o), 32'(e.en));
        chk("sb_kp", 32'(bus.kp_o), 32'(e.kp));
        chk("sb_ki", 32'(bus.ki_o), 32'(e.ki));
        chk("sb_locked", 32'(bus.locked_o), 32'(e.lk));
        chk("sb_fault", 32'(bus.fault_o), 32'(e.ft));
      end
      prev_st = bus.state_o;
    end
  end

  initial begin
    bus.start_i   = 1'b0;
    bus.ref_clk_i = 1'b0;
    bus.error_i   = '0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(bus.state_o), 0);
    chk("rst_enable", 32'(bus.enable_o), 0);
    chk("rst_kp", 32'(bus.kp_o), 32'h2);
    chk("rst_ki", 32'(bus.ki_o), 32'h1);
    chk("rst_locked", 32'(bus.locked_o), 0);
    chk("rst_lost", 32'(bus.lock_lost_o), 0);
    chk("rst_fault", 32'(bus.fault_o), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Acquisition with zero error
    push(COARSE);
    bus.start_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("s1_coarse", 32'(bus.state_o), 32'(COARSE));
    chk("s1_kp_coarse", 32'(bus.kp_o), 32'h4);
    push(FINE);
    pulse(8'sd0, 7);
    chk("s1_7_strobes", 32'(bus.state_o), 32'(COARSE));
    pulse(8'sd0, 1);
    chk("s1_fine", 32'(bus.state_o), 32'(FINE));
    push(LOCKED);
    pulse(8'sd0, 15);
    chk("s1_15_strobes", 32'(bus.state_o), 32'(FINE));
    pulse(8'sd0, 1);
    chk("s1_locked", 32'(bus.state_o), 32'(LOCKED));
    chk("s1_locked_o", 32'(bus.locked_o), 1);
    chk("s1_kp_fine", 32'(bus.kp_o), 32'h2);

    // Unlock run cleared by an in-window strobe, then a true unlock
    pulse(-8'sd3, 3);
    pulse(8'sd0, 1);
    pulse(8'sd3, 3);
    chk("s3_still_locked", 32'(bus.state_o), 32'(LOCKED));
    lost_base = lost_cnt;
    push(COARSE);
    pulse(8'sd3, 1);
    repeat (4) @(negedge clk);
    chk("s3_coarse", 32'(bus.state_o), 32'(COARSE));
    chk("s3_lost_pulse", 32'(lost_cnt - lost_base), 1);

    // -128 saturates to 127: outside window, clears the run
    pulse(-8'sd128, 10);
    chk("s4_neg_sat", 32'(bus.state_o), 32'(COARSE));
    pulse(8'sd8, 7);
    pulse(-8'sd128, 1);
    pulse(-8'sd8, 7);
    chk("s4_run_cleared", 32'(bus.state_o), 32'(COARSE));
    push(FINE);
    pulse(8'sd8, 1);
    chk("s4_fine_edge", 32'(bus.state_o), 32'(FINE));

    // FINE: mid-window error clears only; beyond coarse window drops back
    pulse(8'sd2, 15);
    pulse(-8'sd8, 1);
    pulse(8'sd2, 15);
    chk("s2_stay_fine", 32'(bus.state_o), 32'(FINE));
    push(COARSE);
    pulse(8'sd9, 1);
    chk("s2_coarse", 32'(bus.state_o), 32'(COARSE));
    chk("s2_kp", 32'(bus.kp_o), 32'h4);
    chk("s2_ki", 32'(bus.ki_o), 32'h4);

    // Re-lock, then drop start
    push(FINE);
    push(LOCKED);
    pulse(8'sd0, 24);
    chk("s5_relocked", 32'(bus.state_o), 32'(LOCKED));
    lost_base = lost_cnt;
    push(IDLE);
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    chk("s5_idle", 32'(bus.state_o), 32'(IDLE));
    chk("s5_enable", 32'(bus.enable_o), 0);
    repeat (3) @(negedge clk);
    chk("s5_no_lost", 32'(lost_cnt - lost_base), 0);

    // Asynchronous reset mid-FINE
    push(COARSE);
    push(FINE);
    bus.start_i = 1'b1;
    repeat (2) @(negedge clk);
    pulse(8'sd0, 11);
    chk("s5_in_fine", 32'(bus.state_o), 32'(FINE));
    push(IDLE);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_rst_state", 32'(bus.state_o), 32'(IDLE));
    chk("s5_rst_enable", 32'(bus.enable_o), 0);
    chk("s5_rst_kp", 32'(bus.kp_o), 32'h2);
    chk("s5_rst_ki", 32'(bus.ki_o), 32'h1);
    repeat (3) @(negedge clk);
    push(COARSE);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("s5_reacq", 32'(bus.state_o), 32'(COARSE));
    pulse(8'sd0, 7);
    chk("s5_progress_lost", 32'(bus.state_o), 32'(COARSE));

    // Large error held through the timeout budget
    pulse(8'sd100, 1);
`ifdef ADPLL_GEAR_TIMEOUT_EN
    push(FAULT);
    pulse(8'sd50, 1030);
    chk("s6_fault_state", 32'(bus.state_o), 32'(FAULT));
    chk("s6_fault_o", 32'(bus.fault_o), 1);
    chk("s6_fault_en", 32'(bus.enable_o), 0);
`else
    pulse(8'sd50, 1030);
    chk("s6_no_fault_state", 32'(bus.state_o), 32'(COARSE));
    chk("s6_no_fault_o", 32'(bus.fault_o), 0);
`endif
    push(IDLE);
    bus.start_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("s6_idle", 32'(bus.state_o), 32'(IDLE));
    chk("s6_fault_clr", 32'(bus.fault_o), 0);

    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adpll_gear_ctrl.md
ADPLL_GEAR_CTRL -- requirements
Module: adpll_gear_ctrl

Interface
REQ-001 The block SHALL have these parameters: ERROR_WIDTH, 8, phase-error width; KP_WIDTH, 3, proportional gain width; KI_WIDTH, 4, integral gain width; KP_COARSE, 3'b100, acquisition Kp; KI_COARSE, 4'b0100, acquisition Ki; KP_FINE, 3'b010, tracking Kp; KI_FINE, 4'b0001, tracking Ki; COARSE_THRESH, 8, coarse-window |error| limit; LOCK_THRESH, 2, lock-window |error| limit; FINE_COUNT, 8, in-window samples to leave COARSE; LOCK_COUNT, 16, in-window samples to declare lock; UNLOCK_COUNT, 4, out-of-window samples to drop lock; TIMEOUT_COUNT, 1024, acquisition sample budget.
REQ-002 The block SHALL have these ports: fpga_clk_i, in, 1, sole clock; reset_n_i, in, 1, asynchronous active-low reset; start_i, in, 1, level request to run the ADPLL; ref_clk_i, in, 1, asynchronous reference clock; error_i, in, ERROR_WIDTH signed, phase-detector error in fpga clock cycles; enable_o, out, 1, ADPLL enable; kp_o, out, KP_WIDTH, Kp to the loop filter; ki_o, out, KI_WIDTH, Ki to the loop filter; locked_o, out, 1, lock indicator; lock_lost_o, out, 1, one-cycle loss-of-lock pulse; fault_o, out, 1, acquisition timeout flag; state_o, out, 3, current state code.

Function
REQ-003 ref_clk_i SHALL pass a two-flop synchronizer; a rising edge of the synchronized signal SHALL produce a one-cycle internal sample strobe, 3 fpga_clk_i cycles after the edge is first captured.
REQ-004 error_i SHALL be sampled only on strobe cycles; |error| SHALL be computed at ERROR_WIDTH bits, with the most negative value saturating to the most positive value (-128 -> 127).
REQ-005 The states SHALL be IDLE=0, COARSE=1, FINE=2, LOCKED=3, FAULT=4.
REQ-006 IDLE: enable_o=0 and the gains SHALL equal the FINE values; start_i=1 SHALL move to COARSE on the next clock.
REQ-007 COARSE: enable_o=1 with COARSE gains; FINE_COUNT consecutive strobes with |err|<=COARSE_THRESH SHALL move to FINE; any strobe outside the window SHALL clear the run counter.
REQ-008 FINE: enable_o=1 with FINE gains; LOCK_COUNT consecutive strobes with |err|<=LOCK_THRESH SHALL move to LOCKED; a single strobe with |err|>COARSE_THRESH SHALL return to COARSE; any other out-of-lock-window strobe SHALL clear the run counter only.
REQ-009 LOCKED: locked_o=1 with FINE gains; UNLOCK_COUNT consecutive strobes with |err|>LOCK_THRESH SHALL move to COARSE and pulse lock_lost_o for exactly 1 cycle; any in-window strobe SHALL clear the run counter.
REQ-010 The run counter SHALL clear on every state transition, and comparisons SHALL be inclusive as stated.
REQ-011 start_i=0 SHALL force IDLE on the next clock from any state, overriding all other transitions without pulsing lock_lost_o.
REQ-012 All outputs SHALL be registered and change in the same cycle as the state register (Moore decode), giving a latency of 1 clock from the deciding strobe.
REQ-013 Counters SHALL saturate and never wrap.

Reset
REQ-014 When reset_n_i=0, the block SHALL asynchronously force IDLE, clear all counters and synchronizer flops, and drive enable_o=0, locked_o=0, lock_lost_o=0, fault_o=0, state_o=0, kp_o=KP_FINE, ki_o=KI_FINE.
REQ-015 Release of reset SHALL be the only way to clear reset effects; a reset asserted mid-acquisition SHALL discard all progress.

Configuration
REQ-016 When macro ADPLL_GEAR_TIMEOUT_EN is defined, a timeout counter SHALL count strobes spent in COARSE or FINE, clear in IDLE and LOCKED, and reaching TIMEOUT_COUNT SHALL move the block to FAULT.
REQ-017 In FAULT, the block SHALL drive enable_o=0 and fault_o=1, and start_i=0 SHALL return it to IDLE with fault_o cleared.
REQ-018 When ADPLL_GEAR_TIMEOUT_EN is undefined, the FAULT state and timeout counter SHALL be absent, fault_o SHALL be tied to 0, and acquisition SHALL be unbounded.

Verification
REQ-019 Scenario 1: reset, then start_i=1 with error_i=0 on every ref edge -> COARSE, then FINE after 8 strobes, then LOCKED after 16 further strobes, with locked_o=1 and kp_o=3'b010.
REQ-020 Scenario 2: in FINE, one strobe with error_i=9 -> COARSE, with kp_o=3'b100 and ki_o=4'b0100 on the next clock.
REQ-021 Scenario 3: in LOCKED, three strobes with error_i=-3 followed by error_i=0 -> still LOCKED; four consecutive strobes with error_i=3 -> COARSE and lock_lost_o high for exactly 1 cycle.
REQ-022 Scenario 4: error_i=-128 held in COARSE -> treated as |err|=127, remaining in COARSE with no counter advance.
REQ-023 Scenario 5: start_i dropped while LOCKED -> IDLE on the next clock with enable_o=0 and lock_lost_o=0; reset_n_i asserted mid-FINE -> immediate IDLE outputs without waiting for a clock edge.
REQ-024 Scenario 6 (macro defined): error_i=50 held -> FAULT after 1024 strobes with fault_o=1; start_i=0 -> IDLE. Same stimulus with the macro undefined -> remains in COARSE with fault_o=0.
